serial_add_sequencer: RTL and testbench
=======================================

SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 Parameter: P_WIDTH, default 8, operand/result width in bits (≥2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request one add/subtract; sampled only in IDLE.
REQ-005 sub  input  1  0 = A+B, 1 = A−B; sampled with start.
REQ-006 op_a  input  P_WIDTH  operand A; sampled with start.
REQ-007 op_b  input  P_WIDTH  operand B; sampled with start.
REQ-008 busy  output  1  high in SHIFT and DONE.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 shift_en  output  1  high on each cycle a serial bit is valid.
REQ-011 ser_a, ser_b  output  1 each  current LSB-first operand bits (ser_b after inversion for sub).
REQ-012 ser_sum  output  1  current LSB-first sum bit, for a downstream serial-to-parallel stage.
REQ-013 oe_n  output  1  active-low output enable for the downstream converter; low only in DONE.
REQ-014 result  output  P_WIDTH  parallel sum, registered, held until next accepted start.
REQ-015 carry_out  output  1  final carry (sub: 1 = no borrow).
REQ-016 overflow  output  1  signed two's-complement overflow of the last operation.

Function
REQ-017 FSM states SHIFT, DONE and IDLE; encoding per shared package.
REQ-018 IDLE & start=1 at edge k: load A←op_a, B←(sub ? ~op_b : op_b), carry←sub, bit counter←0; go to SHIFT.
REQ-019 SHIFT occupies exactly P_WIDTH cycles (k+1 .. k+P_WIDTH), with shift_en=1 throughout.
REQ-020 Each SHIFT cycle is combinational: ser_a=A[0], ser_b=B[0], ser_sum=A[0]^B[0]^carry.
REQ-021 Each SHIFT edge: carry←majority(A[0],B[0],carry); A,B shift right; result shifts right with ser_sum into the MSB; counter increments.
REQ-022 On the edge where counter=P_WIDTH−1, go to DONE, latch carry_out from the final carry, and latch overflow = carry into MSB XOR carry out of MSB.
REQ-023 DONE lasts exactly one cycle (k+P_WIDTH+1): done=1, oe_n=0, busy=1, shift_en=0; then go to IDLE.
REQ-024 Total latency: start at edge k → done high in cycle k+P_WIDTH+1; result is final at that cycle and stays stable.
REQ-025 start while busy (SHIFT or DONE) is ignored and not queued; the next start is accepted in IDLE, giving a minimum spacing of P_WIDTH+2 cycles between accepted starts.
REQ-026 Outside SHIFT: shift_en=0, ser_a=ser_b=ser_sum=0.
REQ-027 Counter width is clog2(P_WIDTH)+1; it never wraps within an operation.
REQ-028 Arithmetic is modulo 2^P_WIDTH; carry_out and overflow are reported separately.

Reset
REQ-029 While rst=1 at an edge: state→IDLE; A, B, result and counter→0; carry, carry_out and overflow→0.
REQ-030 Reset values of outputs: busy=0, done=0, shift_en=0, oe_n=1, ser_*=0.
REQ-031 rst asserted mid-SHIFT or in DONE aborts the operation with no done pulse; start is ignored in the cycle rst=1.

Structure
REQ-032 A shared package serial_cpu_pkg holds the FSM state typedef (IDLE/SHIFT/DONE) and the default width constant of 8.
REQ-033 The single sub-module serial_full_adder holds the one-bit sum/carry logic and the carry flip-flop, with inputs load, load_val and en; everything else lives in the top.

Verification
REQ-034 P_WIDTH=8, op_a=0x5A, op_b=0x3C, sub=0 → done at cycle k+9; result=0x96, carry_out=0, overflow=1; ser_sum sequence LSB-first 0,1,1,0,1,0,0,1.
REQ-035 op_a=0xFF, op_b=0x01, sub=0 → result=0x00, carry_out=1, overflow=0.
REQ-036 op_a=0x10, op_b=0x20, sub=1 → result=0xF0, carry_out=0, overflow=0; op_a=0x80, op_b=0x01, sub=1 → result=0x7F, overflow=1.
REQ-037 start held high continuously with op_a=0x01, op_b=0x01 → accepted starts every 10 cycles, each giving result=0x02; mid-operation op changes have no effect.
REQ-038 rst pulsed at SHIFT cycle 4 → next cycle busy=0, oe_n=1, result=0x00, no done pulse; a following start completes normally.
REQ-039 Throughout all scenarios: shift_en is high for exactly P_WIDTH cycles per operation, and oe_n is low only in cycles where done=1.

Source files
------------

// File: rtl/serial_cpu_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state type,
// default datapath width and the one-bit carry function.
package serial_cpu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_full_adder.sv
// One-bit serial full adder: combinational sum/carry plus the carry flip-flop
// that links successive bit positions.
module serial_full_adder
  import serial_cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_val,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry_r,
  output logic carry_next
);

  assign sum        = a ^ b ^ carry_r;
  assign carry_next = majority(a, b, carry_r);

  // carry register: cleared by reset, preset on load, advanced once per bit
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_r <= 1'b0;
    end else if (load) begin
      carry_r <= load_val;
    end else if (en) begin
      carry_r <= carry_next;
    end else begin
      carry_r <= carry_r;
    end
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract sequencer: loads two operands, streams them LSB-first
// through a one-bit adder and collects the parallel result.
module serial_add_sequencer
  import serial_cpu_pkg::*;
#(
  parameter int P_WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic [P_WIDTH-1:0] op_a,
  input  logic [P_WIDTH-1:0] op_b,
  output logic               busy,
  output logic               done,
  output logic               shift_en,
  output logic               ser_a,
  output logic               ser_b,
  output logic               ser_sum,
  output logic               oe_n,
  output logic [P_WIDTH-1:0] result,
  output logic               carry_out,
  output logic               overflow
);

  localparam int CNT_W = $clog2(P_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(P_WIDTH - 1);

  state_e             state_r;
  state_e             state_s;
  logic [P_WIDTH-1:0] a_r;
  logic [P_WIDTH-1:0] b_r;
  logic [P_WIDTH-1:0] result_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               carry_out_r;
  logic               overflow_r;
  logic               accept_s;
  logic               shifting_s;
  logic               last_s;
  logic               sum_s;
  logic               carry_r;
  logic               carry_next_s;

  assign accept_s   = (state_r == IDLE) && start;
  assign shifting_s = (state_r == SHIFT);
  assign last_s     = shifting_s && (cnt_r == LAST_BIT);

  // subtraction is A + ~B + 1, so the carry is preset with sub on load
  serial_full_adder u_fa (
    .clk        (clk),
    .rst        (rst),
    .load       (accept_s),
    .load_val   (sub),
    .en         (shifting_s),
    .a          (a_r[0]),
    .b          (b_r[0]),
    .sum        (sum_s),
    .carry_r    (carry_r),
    .carry_next (carry_next_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = SHIFT;
        else       state_s = IDLE;
      end
      SHIFT: begin
        if (cnt_r == LAST_BIT) state_s = DONE;
        else                   state_s = SHIFT;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // output decode; serial bits are forced low outside SHIFT
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    shift_en = 1'b0;
    oe_n     = 1'b1;
    ser_a    = 1'b0;
    ser_b    = 1'b0;
    ser_sum  = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        ser_a    = a_r[0];
        ser_b    = b_r[0];
        ser_sum  = sum_s;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        oe_n = 1'b0;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // operand shifters, result collector, bit counter and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= '0;
      b_r         <= '0;
      result_r    <= '0;
      cnt_r       <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (accept_s) begin
      a_r   <= op_a;
      b_r   <= sub ? ~op_b : op_b;
      cnt_r <= '0;
    end else if (shifting_s) begin
      a_r      <= {1'b0, a_r[P_WIDTH-1:1]};
      b_r      <= {1'b0, b_r[P_WIDTH-1:1]};
      result_r <= {sum_s, result_r[P_WIDTH-1:1]};
      cnt_r    <= cnt_r + CNT_W'(1);
      if (last_s) begin
        // on the MSB, carry_r is the carry in and carry_next_s the carry out
        carry_out_r <= carry_next_s;
        overflow_r  <= carry_r ^ carry_next_s;
      end else begin
        carry_out_r <= carry_out_r;
        overflow_r  <= overflow_r;
      end
    end else begin
      a_r <= a_r;
    end
  end

  assign result    = result_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer: directed vectors, random
// operations against an arithmetic reference, back-to-back starts and reset abort.
module tb_serial_add_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done, shift_en, ser_a, ser_b, ser_sum, oe_n;
  logic         carry_out, overflow;
  logic [W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  serial_add_sequencer #(.P_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .shift_en  (shift_en),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_sum   (ser_sum),
    .oe_n      (oe_n),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One full operation from IDLE: checks every serial cycle, the DONE cycle
  // and the IDLE cycle after it. Operands are scrambled once accepted.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] eb, exp_res;
    logic         exp_c, exp_v;
    int           sr;
    eb      = s ? ~b : b;
    exp_res = s ? (a - b) : (a + b);
    exp_c   = s ? (a >= b) : ((int'(a) + int'(b)) > 255);
    sr      = s ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    exp_v   = (sr > 127) || (sr < -128);
    @(negedge clk);
    start = 1'b1; sub = s; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      n_tests++;
      if ({busy, done, shift_en, oe_n} !== 4'b1011) begin
        n_fail++;
        $display("FAIL shift_flags bit %0d: got %b expected 1011", i, {busy, done, shift_en, oe_n});
      end
      n_tests++;
      if ({ser_a, ser_b} !== {a[i], eb[i]}) begin
        n_fail++;
        $display("FAIL ser_ab bit %0d: got %b expected %b", i, {ser_a, ser_b}, {a[i], eb[i]});
      end
      n_tests++;
      if (ser_sum !== exp_res[i]) begin
        n_fail++;
        $display("FAIL ser_sum bit %0d (a=%h b=%h sub=%b): got %b expected %b", i, a, b, s, ser_sum, exp_res[i]);
      end
      op_a = W'($urandom); op_b = W'($urandom);
    end
    @(negedge clk);
    n_tests++;
    if ({busy, done, shift_en, oe_n} !== 4'b1100) begin
      n_fail++;
      $display("FAIL done_flags: got %b expected 1100", {busy, done, shift_en, oe_n});
    end
    n_tests++;
    if ({result, carry_out, overflow} !== {exp_res, exp_c, exp_v}) begin
      n_fail++;
      $display("FAIL result (a=%h b=%h sub=%b): got %h c=%b v=%b expected %h c=%b v=%b",
               a, b, s, result, carry_out, overflow, exp_res, exp_c, exp_v);
    end
    @(negedge clk);
    n_tests++;
    if ({busy, done, shift_en, oe_n, ser_a, ser_b, ser_sum} !== 7'b0001000) begin
      n_fail++;
      $display("FAIL idle_after_done: got %b expected 0001000", {busy, done, shift_en, oe_n, ser_a, ser_b, ser_sum});
    end
    n_tests++;
    if (result !== exp_res) begin
      n_fail++;
      $display("FAIL result_hold: got %h expected %h", result, exp_res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, done, shift_en, oe_n, ser_a, ser_b, ser_sum} !== 7'b0001000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0001000", {busy, done, shift_en, oe_n, ser_a, ser_b, ser_sum});
    end
    n_tests++;
    if ({result, carry_out, overflow} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_result: got %h c=%b v=%b expected 00 c=0 v=0", result, carry_out, overflow);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(8'h5A, 8'h3C, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h10, 8'h20, 1'b1);
    run_op(8'h80, 8'h01, 1'b1);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'h7F, 8'h7F, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  // start held high: accepts must be exactly W+2 cycles apart
  task automatic test_back_to_back();
    int last_done;
    last_done = 0;
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 8'h01; op_b = 8'h01;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        n_tests++;
        if ({busy, done, shift_en, oe_n} !== 4'b1011) begin
          n_fail++;
          $display("FAIL b2b_shift op %0d bit %0d: got %b expected 1011", j, i, {busy, done, shift_en, oe_n});
        end
        op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
      end
      @(negedge clk);
      n_tests++;
      if ({done, oe_n, result} !== {1'b1, 1'b0, 8'h02}) begin
        n_fail++;
        $display("FAIL b2b_done op %0d: got done=%b oe_n=%b result=%h expected done=1 oe_n=0 result=02", j, done, oe_n, result);
      end
      if (j > 0) begin
        n_tests++;
        if (cyc - last_done !== W + 2) begin
          n_fail++;
          $display("FAIL b2b_spacing op %0d: got %0d expected %0d", j, cyc - last_done, W + 2);
        end
      end
      last_done = cyc;
      op_a = 8'h01; op_b = 8'h01; sub = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({busy, done, shift_en, oe_n} !== 4'b0001) begin
        n_fail++;
        $display("FAIL b2b_idle op %0d: got %b expected 0001", j, {busy, done, shift_en, oe_n});
      end
    end
    start = 1'b0;
  endtask

  // reset in the fourth serial cycle aborts without a done pulse
  task automatic test_reset_abort();
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 8'h5A; op_b = 8'h3C;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (shift_en !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: got shift_en=%b expected 1", shift_en);
    end
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({busy, done, shift_en, oe_n, result, carry_out, overflow} !== {4'b0001, 8'h00, 2'b00}) begin
        n_fail++;
        $display("FAIL abort_idle cycle %0d: got flags=%b result=%h c=%b v=%b expected flags=0001 result=00 c=0 v=0",
                 i, {busy, done, shift_en, oe_n}, result, carry_out, overflow);
      end
    end
    run_op(8'h5A, 8'h3C, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
